// File: rtl/upsizer_pkg.sv
// Shared configuration and entry type for the upsizer pack FIFO.
// Widths are fixed here so every stage agrees on the entry layout.
package upsizer_pkg;

  localparam int IN_WIDTH   = 32;
  localparam int RATIO      = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int OUT_WIDTH  = IN_WIDTH * RATIO;
  localparam int LANE_W     = $clog2(RATIO);
  localparam int PTR_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W      = PTR_W - 1;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic [RATIO-1:0]     keep;
    logic                 last;
  } entry_t;

endpackage

// File: rtl/upsizer_pack_stage.sv
// Packs narrow beats into one wide entry; emits a push strobe
// together with the completed entry on the closing beat.
module upsizer_pack_stage
  import upsizer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_last,
  input  logic                in_valid,
  input  logic                in_ready,
  output logic                push,
  output entry_t              entry
);

  logic [LANE_W-1:0]    lane;
  logic [RATIO-1:0]     keep;
  logic [OUT_WIDTH-1:0] data;
  logic [RATIO-1:0]     nxt_keep;
  logic [OUT_WIDTH-1:0] nxt_data;
  logic                 accept;
  logic                 close;

  assign accept = in_valid && in_ready;
  assign close  = accept &&
                  (lane == LANE_W'(RATIO - 1) || in_last);

  // Word as it would look with the current beat merged in.
  always_comb begin
    nxt_data = data;
    nxt_keep = keep;
    nxt_data[int'(lane)*IN_WIDTH +: IN_WIDTH] = in_data;
    nxt_keep[lane] = 1'b1;
  end

  assign push       = close;
  assign entry.data = nxt_data;
  assign entry.keep = nxt_keep;
  assign entry.last = in_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
      keep <= '0;
      data <= '0;
    end else if (accept) begin
      if (close) begin
        lane <= '0;
        keep <= '0;
        data <= '0;
      end else begin
        lane <= lane + LANE_W'(1);
        keep <= nxt_keep;
        data <= nxt_data;
      end
    end
  end

endmodule

// File: rtl/upsizer_pack_fifo.sv
// Narrow-to-wide packing FIFO: pack stage feeding a circular
// buffer of wide entries with first-word-fall-through read.
module upsizer_pack_fifo
  import upsizer_pkg::*;
#(
  parameter int AF_LEVEL = FIFO_DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic                 in_last_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic [RATIO-1:0]     out_keep_o,
  output logic                 out_last_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PTR_W-1:0]     count_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic                 full_o,
  output logic                 empty_o
);

  entry_t           mem [FIFO_DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  upsizer_pack_stage u_pack (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data_i),
    .in_last  (in_last_i),
    .in_valid (in_valid_i),
    .in_ready (in_ready_o),
    .push     (push),
    .entry    (wr_entry)
  );

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_idx == rd_idx) &&
                   (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
  assign count_o = wr_ptr - rd_ptr;

  assign almost_full_o  = count_o >= PTR_W'(AF_LEVEL);
  assign almost_empty_o = count_o <= PTR_W'(AE_LEVEL);

  assign in_ready_o  = !full_o;
  assign out_valid_o = !empty_o;
  assign pop         = out_valid_o && out_ready_i;

  // Head is masked while empty so stale storage never leaks out.
  assign head       = empty_o ? '0 : mem[rd_idx];
  assign out_data_o = head.data;
  assign out_keep_o = head.keep;
  assign out_last_o = head.last;

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_upsizer_pack_fifo.sv
// Bench for upsizer_pack_fifo: queue-based reference model,
// per-cycle compare, directed cases plus random traffic.
module tb_upsizer_pack_fifo;
  import upsizer_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [IN_WIDTH-1:0]  in_data_i = '0;
  logic                 in_last_i = 1'b0;
  logic                 in_valid_i = 1'b0;
  logic                 in_ready_o;
  logic [OUT_WIDTH-1:0] out_data_o;
  logic [RATIO-1:0]     out_keep_o;
  logic                 out_last_o;
  logic                 out_valid_o;
  logic                 out_ready_i = 1'b0;
  logic [PTR_W-1:0]     count_o;
  logic                 almost_full_o;
  logic                 almost_empty_o;
  logic                 full_o;
  logic                 empty_o;

  int total = 0;
  int bad   = 0;

  upsizer_pack_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .in_data_i      (in_data_i),
    .in_last_i      (in_last_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .out_data_o     (out_data_o),
    .out_keep_o     (out_keep_o),
    .out_last_o     (out_last_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .count_o        (count_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .full_o         (full_o),
    .empty_o        (empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_WIDTH-1:0] d;
    logic [RATIO-1:0]     k;
    logic                 l;
  } exp_t;

  exp_t                q[$];
  logic [IN_WIDTH-1:0] pend[$];

  task automatic chk(input string nm,
                     input logic [OUT_WIDTH-1:0] act,
                     input logic [OUT_WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending beats in a queue, words in another.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      pend.delete();
    end else begin
      bit acc;
      bit pp;
      exp_t e;
      acc = in_valid_i && (q.size() < FIFO_DEPTH);
      pp  = (q.size() > 0) && out_ready_i;
      if (pp) void'(q.pop_front());
      if (acc) begin
        pend.push_back(in_data_i);
        if (pend.size() == RATIO || in_last_i) begin
          e.d = '0;
          e.k = '0;
          for (int i = 0; i < pend.size(); i++) begin
            e.d = e.d | (OUT_WIDTH'(pend[i]) << (i * IN_WIDTH));
            e.k[i] = 1'b1;
          end
          e.l = in_last_i;
          q.push_back(e);
          pend.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", out_valid_o, q.size() > 0);
      chk("ready", in_ready_o, q.size() < FIFO_DEPTH);
      chk("count", count_o, q.size());
      chk("full", full_o, q.size() == FIFO_DEPTH);
      chk("empty", empty_o, q.size() == 0);
      chk("afull", almost_full_o, q.size() >= FIFO_DEPTH - 2);
      chk("aempty", almost_empty_o, q.size() <= 1);
      if (q.size() > 0) begin
        chk("data", out_data_o, q[0].d);
        chk("keep", out_keep_o, q[0].k);
        chk("last", out_last_o, q[0].l);
      end
    end
  end

  task automatic send(input logic [IN_WIDTH-1:0] d,
                      input logic l);
    int  n;
    logic acc;
    n = 0;
    in_data_i  = d;
    in_last_i  = l;
    in_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        bad++;
        total++;
        $display("FAIL send_timeout act=stalled exp=accept");
        break;
      end
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic send_word(input int base);
    for (int i = 0; i < RATIO; i++)
      send(IN_WIDTH'(base + i), 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", in_ready_o, 1'b1);
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_data", out_data_o, '0);
    chk("rst_keep", out_keep_o, '0);
    chk("rst_last", out_last_o, 1'b0);
    chk("rst_count", count_o, '0);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_aempty", almost_empty_o, 1'b1);
    chk("rst_full", full_o, 1'b0);
    chk("rst_afull", almost_full_o, 1'b0);
  endtask

  initial begin
    logic [OUT_WIDTH-1:0] w;
    #2;
    chk_reset_vals();
    #20 rst = 1'b0;
    @(posedge clk); #1;

    // Full pack
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b0);
    send(32'h44, 1'b0);
    chk("pack_valid", out_valid_o, 1'b1);
    w = {32'h44, 32'h33, 32'h22, 32'h11};
    chk("pack_data", out_data_o, w);
    chk("pack_keep", out_keep_o, 4'b1111);
    chk("pack_last", out_last_o, 1'b0);

    // Partial flush, then next beat lands in lane 0
    send(32'hAA, 1'b0);
    send(32'hBB, 1'b1);
    send(32'hCC, 1'b1);
    chk("three_cnt", count_o, 3);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    w = {32'h0, 32'h0, 32'hBB, 32'hAA};
    chk("part_data", out_data_o, w);
    chk("part_keep", out_keep_o, 4'b0011);
    chk("part_last", out_last_o, 1'b1);
    @(posedge clk); #1;
    w = {32'h0, 32'h0, 32'h0, 32'hCC};
    chk("lane0_data", out_data_o, w);
    chk("lane0_keep", out_keep_o, 4'b0001);
    @(posedge clk); #1;
    out_ready_i = 1'b0;

    // Reset mid-word with a complete word also stored
    send_word(32'h100);
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    #3 rst = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    send(32'h5, 1'b0);
    send(32'h6, 1'b0);
    send(32'h7, 1'b0);
    send(32'h8, 1'b0);
    w = {32'h8, 32'h7, 32'h6, 32'h5};
    chk("fresh_data", out_data_o, w);
    chk("fresh_keep", out_keep_o, 4'b1111);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;

    // Fill to full
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      send_word(i * 16);
      if (i == 12) chk("af_13", almost_full_o, 1'b0);
      if (i == 13) chk("af_14", almost_full_o, 1'b1);
    end
    chk("fill_full", full_o, 1'b1);
    chk("fill_ready", in_ready_o, 1'b0);
    chk("fill_cnt", count_o, 16);
    in_data_i  = 32'hDEAD;
    in_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid_i = 1'b0;
    chk("stall_cnt", count_o, 16);

    // Drain and refill across the wrap
    out_ready_i = 1'b1;
    repeat (FIFO_DEPTH) @(posedge clk);
    #1 out_ready_i = 1'b0;
    chk("drained", empty_o, 1'b1);
    for (int i = 0; i < 5; i++) send_word(32'h1000 + i * 16);
    chk("refill_cnt", count_o, 5);
    w = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    chk("wrap_head", out_data_o, w);

    // Concurrent push and pop at count 3
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready_i = 1'b0;
    chk("pre_cc_cnt", count_o, 3);
    send(32'h71, 1'b0);
    send(32'h72, 1'b0);
    send(32'h73, 1'b0);
    in_data_i   = 32'h74;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    chk("cc_cnt", count_o, 3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid_i  = ($urandom % 4) != 0;
      in_last_i   = ($urandom % 6) == 0;
      in_data_i   = $urandom;
      if ((i / 400) % 2 == 1)
        out_ready_i = ($urandom % 4) == 0;
      else
        out_ready_i = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (FIFO_DEPTH + 2) @(posedge clk);
    #1;
    chk("end_empty", empty_o, 1'b1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
